// File: rtl/count_run_ctrl_pkg.sv
// Shared types and constants for the run/stop/step controller of the BCD counter.
package count_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam int unsigned STABLE_CYC_DEF = 1048576;

endpackage

// File: rtl/count_run_ctrl_if.sv
// Signal bundle between the controller, its buttons/divider and the BCD counter.
// Every strobe here is a single-cycle pulse with no ready/acknowledge path: the
// receiver samples it on the next rising clock edge.
interface count_run_ctrl_if;
  import count_run_ctrl_pkg::*;

  logic   btn_run;
  logic   btn_step;
  logic   tick;
  logic   carry_in;
  logic   count_en;
  logic   count_clr;
  logic   running;
  logic   halted;
  logic   run_level;
  logic   step_level;
  state_t state_dbg;

  modport master (
    input  btn_run, btn_step, tick, carry_in,
    output count_en, count_clr, running, halted, run_level, step_level, state_dbg
  );

  modport slave (
    output btn_run, btn_step, tick, carry_in,
    input  count_en, count_clr, running, halted, run_level, step_level, state_dbg
  );

endinterface

// File: rtl/count_run_ctrl_btn_debounce.sv
// Raw pushbutton conditioner: 2-flop synchronizer, stability counter and rising-edge press pulse.
module btn_debounce
  import count_run_ctrl_pkg::*;
#(
  parameter int unsigned STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter measures how long the synced input has disagreed with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/count_run_ctrl.sv
// Run/stop/single-step FSM gating the divider tick into count-enable and clear pulses.
module count_run_ctrl
  import count_run_ctrl_pkg::*;
#(
  parameter int unsigned STABLE_CYC = STABLE_CYC_DEF,
  parameter bit          AUTO_STOP  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  count_run_ctrl_if.master bus
);

  logic   run_press, step_press;
  logic   run_level, step_level;
  state_t state_q, state_d;
  logic   count_en_c, count_clr_c;
  logic   at_stop;

  btn_debounce #(.STABLE_CYC(STABLE_CYC)) u_run_db (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (bus.btn_run),
    .level_o (run_level),
    .press_o (run_press)
  );

  btn_debounce #(.STABLE_CYC(STABLE_CYC)) u_step_db (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (bus.btn_step),
    .level_o (step_level),
    .press_o (step_press)
  );

  assign at_stop = AUTO_STOP && bus.carry_in;

  // Presses are checked before the tick so a press always suppresses that cycle's pulse.
  always_comb begin
    state_d     = state_q;
    count_en_c  = 1'b0;
    count_clr_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run_press)       state_d = RUN;
        else if (step_press) state_d = STEP;
      end
      RUN: begin
        if (run_press) begin
          state_d = IDLE;
        end else if (bus.tick) begin
          if (at_stop) state_d = HALT;
          else         count_en_c = 1'b1;
        end
      end
      STEP: begin
        if (run_press) begin
          state_d = RUN;
        end else if (bus.tick) begin
          if (at_stop) begin
            state_d = HALT;
          end else begin
            count_en_c = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      HALT: begin
        if (run_press) begin
          state_d     = IDLE;
          count_clr_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign bus.count_en   = count_en_c;
  assign bus.count_clr  = count_clr_c;
  assign bus.running    = (state_q == RUN);
  assign bus.halted     = (state_q == HALT);
  assign bus.run_level  = run_level;
  assign bus.step_level = step_level;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
// Directed bench for count_run_ctrl with STABLE_CYC=4; dut_b covers the free-wrapping variant.
module tb_count_run_ctrl;
  import count_run_ctrl_pkg::*;

  localparam int unsigned SC = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  count_run_ctrl_if bus_a ();
  count_run_ctrl_if bus_b ();

  count_run_ctrl #(.STABLE_CYC(SC), .AUTO_STOP(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  count_run_ctrl #(.STABLE_CYC(SC), .AUTO_STOP(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int vectors     = 0;
  int miscompares = 0;
  int en_cnt      = 0;
  int clr_cnt     = 0;
  int stray_en    = 0;
  int trans_cnt   = 0;
  state_t prev_state = IDLE;
  int en0, stray0, t0, c0;

  // Pulse and transition monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus_a.count_en) begin
      en_cnt++;
      if (!bus_a.tick) stray_en++;
    end
    if (bus_a.count_clr) clr_cnt++;
    if (bus_a.state_dbg != prev_state) trans_cnt++;
    prev_state = bus_a.state_dbg;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press_a(input logic r, input logic s, input int hold);
    bus_a.btn_run  = r;
    bus_a.btn_step = s;
    cyc(hold);
    bus_a.btn_run  = 1'b0;
    bus_a.btn_step = 1'b0;
    cyc(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.btn_run = 1'b0; bus_a.btn_step = 1'b0; bus_a.tick = 1'b0; bus_a.carry_in = 1'b0;
    bus_b.btn_run = 1'b0; bus_b.btn_step = 1'b0; bus_b.tick = 1'b0; bus_b.carry_in = 1'b0;
    reset = 1'b0;
    #3;
    check("rst running", bus_a.running, 0);
    check("rst halted", bus_a.halted, 0);
    check("rst count_en", bus_a.count_en, 0);
    check("rst count_clr", bus_a.count_clr, 0);
    check("rst state", bus_a.state_dbg, IDLE);
    cyc(2);
    reset = 1'b1;
    cyc(1);

    // 1: reach RUN, async reset mid-run, then run again and count 5 ticks
    bus_a.btn_run = 1'b1;
    cyc(6);
    check("s1 level flipped", bus_a.run_level, 1);
    check("s1 not yet running", bus_a.running, 0);
    cyc(1);
    check("s1 running edge6", bus_a.running, 1);
    cyc(3);
    bus_a.btn_run = 1'b0;
    cyc(8);
    bus_a.tick = 1'b1;
    #1;
    check("s1 en before reset", bus_a.count_en, 1);
    reset = 1'b0;
    #1;
    check("s1 async running", bus_a.running, 0);
    check("s1 async count_en", bus_a.count_en, 0);
    check("s1 async state", bus_a.state_dbg, IDLE);
    bus_a.tick = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    bus_a.btn_run = 1'b1;
    cyc(6);
    check("s1b not yet running", bus_a.running, 0);
    cyc(1);
    check("s1b running edge6", bus_a.running, 1);
    cyc(3);
    bus_a.btn_run = 1'b0;
    cyc(8);
    en0 = en_cnt; stray0 = stray_en;
    for (int i = 0; i < 5; i++) begin
      bus_a.tick = 1'b1;
      #1;
      check("s1 tick en", bus_a.count_en, 1);
      cyc(1);
      bus_a.tick = 1'b0;
      #1;
      check("s1 idle en", bus_a.count_en, 0);
      cyc(1);
    end
    check("s1 five pulses", en_cnt - en0, 5);
    check("s1 stray pulses", stray_en - stray0, 0);

    // 2: glitch and bounce
    t0 = trans_cnt;
    bus_a.btn_run = 1'b1;
    cyc(3);
    bus_a.btn_run = 1'b0;
    cyc(10);
    check("s2 glitch running", bus_a.running, 1);
    check("s2 glitch trans", trans_cnt - t0, 0);
    repeat (3) begin
      bus_a.btn_run = 1'b1;
      cyc(1);
      bus_a.btn_run = 1'b0;
      cyc(1);
    end
    bus_a.btn_run = 1'b1;
    cyc(8);
    bus_a.btn_run = 1'b0;
    cyc(10);
    check("s2 bounce trans", trans_cnt - t0, 1);
    check("s2 bounce state", bus_a.state_dbg, IDLE);

    // 3: single step, repeated step press ignored
    en0 = en_cnt;
    press_a(1'b0, 1'b1, 8);
    check("s3 in step", bus_a.state_dbg, STEP);
    press_a(1'b0, 1'b1, 8);
    check("s3 step again", bus_a.state_dbg, STEP);
    check("s3 no pulse yet", en_cnt - en0, 0);
    for (int i = 0; i < 3; i++) begin
      bus_a.tick = 1'b1;
      cyc(1);
      bus_a.tick = 1'b0;
      cyc(1);
    end
    check("s3 one pulse", en_cnt - en0, 1);
    check("s3 back idle", bus_a.state_dbg, IDLE);

    // 4: same-cycle conflicts
    press_a(1'b1, 1'b1, 8);
    check("s4 both presses", bus_a.state_dbg, RUN);
    bus_a.btn_run = 1'b1;
    cyc(6);
    bus_a.tick = 1'b1;
    #1;
    check("s4 press beats tick", bus_a.count_en, 0);
    check("s4 still run", bus_a.state_dbg, RUN);
    cyc(1);
    check("s4 to idle", bus_a.state_dbg, IDLE);
    check("s4 idle tick en", bus_a.count_en, 0);
    bus_a.tick = 1'b0;
    bus_a.btn_run = 1'b0;
    cyc(8);
    check("s4 release no press", bus_a.state_dbg, IDLE);

    // 5: auto-stop at terminal count, step ignored in HALT, restart clears
    press_a(1'b1, 1'b0, 8);
    check("s5 running", bus_a.running, 1);
    bus_a.carry_in = 1'b1;
    bus_a.tick = 1'b1;
    #1;
    check("s5 no en at carry", bus_a.count_en, 0);
    cyc(1);
    bus_a.tick = 1'b0;
    check("s5 halted", bus_a.halted, 1);
    check("s5 not running", bus_a.running, 0);
    en0 = en_cnt;
    press_a(1'b0, 1'b1, 8);
    check("s5 step ignored", bus_a.halted, 1);
    check("s5 step no en", en_cnt - en0, 0);
    c0 = clr_cnt;
    bus_a.btn_run = 1'b1;
    cyc(6);
    check("s5 clr pulse", bus_a.count_clr, 1);
    check("s5 clr no en", bus_a.count_en, 0);
    cyc(1);
    check("s5 clr done", bus_a.count_clr, 0);
    check("s5 idle", bus_a.state_dbg, IDLE);
    bus_a.btn_run = 1'b0;
    cyc(8);
    check("s5 one clr", clr_cnt - c0, 1);
    bus_a.carry_in = 1'b0;

    // 6: AUTO_STOP=0 counts through the carry
    bus_b.btn_run = 1'b1;
    cyc(7);
    check("s6 running", bus_b.running, 1);
    bus_b.btn_run = 1'b0;
    cyc(8);
    bus_b.carry_in = 1'b1;
    bus_b.tick = 1'b1;
    #1;
    check("s6 en at carry", bus_b.count_en, 1);
    cyc(1);
    bus_b.tick = 1'b0;
    bus_b.carry_in = 1'b0;
    check("s6 not halted", bus_b.halted, 0);
    check("s6 still running", bus_b.running, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
